// File: rtl/regex_cmdq_pkg.sv
// Shared types for the regex accelerator command queue: FSM states and the
// command/result records carried through the two FIFOs.
package regex_cmdq_pkg;

  localparam int CMDQ_ADDR_W = 8;
  localparam int CMDQ_LEN_W  = 16;
  localparam int CMDQ_TAG_W  = 8;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    GUARD,
    WAIT,
    REPORT
  } cmdq_state_e;

  // Record widths follow the package widths; the top defaults to the same values.
  typedef struct packed {
    logic [CMDQ_ADDR_W-1:0] addr;
    logic [CMDQ_LEN_W-1:0]  len;
    logic [CMDQ_TAG_W-1:0]  tag;
  } cmdq_cmd_t;

  typedef struct packed {
    logic [CMDQ_TAG_W-1:0] tag;
    logic                  match;
  } cmdq_res_t;

endpackage

// File: rtl/regex_cmdq_fifo.sv
// Synchronous FIFO with wrap-bit pointers (modulo 2*DEPTH) and a registered
// occupancy count. A push while full is accepted only when a pop frees the slot.
module regex_cmdq_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ONE;
      if (do_pop)  rd_ptr <= rd_ptr + ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/regex_cmd_queue.sv
// Command queue in front of regex_acc: serialises tagged scan commands onto the
// single-outstanding accelerator port and collects tagged results in order.
// Optional scan/match statistics counters: define REGEX_CMDQ_STATS_EN.
module regex_cmd_queue
  import regex_cmdq_pkg::*;
#(
  parameter int PMEM_ADDR_WIDTH = CMDQ_ADDR_W,
  parameter int LEN_WIDTH       = CMDQ_LEN_W,
  parameter int TAG_WIDTH       = CMDQ_TAG_W,
  parameter int CMD_DEPTH       = 8,
  parameter int RES_DEPTH       = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [PMEM_ADDR_WIDTH-1:0]   enq_addr,
  input  logic [LEN_WIDTH-1:0]         enq_len,
  input  logic [TAG_WIDTH-1:0]         enq_tag,
  input  logic                         enq_valid,
  output logic                         enq_ready,
  output logic [PMEM_ADDR_WIDTH-1:0]   acc_cmd_addr,
  output logic [LEN_WIDTH-1:0]         acc_cmd_len,
  output logic                         acc_cmd_valid,
  input  logic                         acc_cmd_ready,
  input  logic                         acc_status_done,
  input  logic                         acc_status_match,
  output logic [TAG_WIDTH-1:0]         res_tag,
  output logic                         res_match,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [$clog2(CMD_DEPTH):0]   cmd_count,
  output logic                         busy,
  output logic [31:0]                  stat_scans,
  output logic [31:0]                  stat_matches
);

  cmdq_state_e state;
  cmdq_state_e state_nxt;

  cmdq_cmd_t cmd_in;
  cmdq_cmd_t cmd_head;
  cmdq_res_t res_in;
  cmdq_res_t res_head;

  logic cmd_empty;
  logic cmd_full;
  logic cmd_pop;
  logic res_empty;
  logic res_full;
  logic res_push;
  logic [$clog2(RES_DEPTH):0] res_count;

  logic load_cur;
  logic latch_match;

  logic [PMEM_ADDR_WIDTH-1:0] cur_addr;
  logic [LEN_WIDTH-1:0]       cur_len;
  logic [TAG_WIDTH-1:0]       cur_tag;
  logic                       cur_match;

  assign cmd_in    = '{addr: enq_addr, len: enq_len, tag: enq_tag};
  assign enq_ready = !cmd_full;

  regex_cmdq_fifo #(
    .WIDTH ($bits(cmdq_cmd_t)),
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (enq_valid && enq_ready),
    .push_data (cmd_in),
    .pop       (cmd_pop),
    .head      (cmd_head),
    .empty     (cmd_empty),
    .full      (cmd_full),
    .count     (cmd_count)
  );

  assign res_in = '{tag: cur_tag, match: cur_match};

  regex_cmdq_fifo #(
    .WIDTH ($bits(cmdq_res_t)),
    .DEPTH (RES_DEPTH)
  ) u_res_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (res_push),
    .push_data (res_in),
    .pop       (res_valid && res_ready),
    .head      (res_head),
    .empty     (res_empty),
    .full      (res_full),
    .count     (res_count)
  );

  assign res_valid = !res_empty;
  assign res_tag   = res_head.tag;
  assign res_match = res_head.match;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    cmd_pop     = 1'b0;
    load_cur    = 1'b0;
    latch_match = 1'b0;
    res_push    = 1'b0;
    case (state)
      IDLE: begin
        if (!cmd_empty) begin
          cmd_pop  = 1'b1;
          load_cur = 1'b1;
          // Zero-length scans never reach the accelerator.
          state_nxt = (cmd_head.len == '0) ? REPORT : ISSUE;
        end
      end
      ISSUE: begin
        if (acc_cmd_ready) state_nxt = GUARD;
      end
      // done still reflects the previous scan for one cycle after issue.
      GUARD:  state_nxt = WAIT;
      WAIT: begin
        if (acc_status_done) begin
          latch_match = 1'b1;
          state_nxt   = REPORT;
        end
      end
      REPORT: begin
        if (!res_full) begin
          res_push  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (load_cur) begin
      cur_addr  <= cmd_head.addr;
      cur_len   <= cmd_head.len;
      cur_tag   <= cmd_head.tag;
      cur_match <= 1'b0;
    end else if (latch_match) begin
      cur_match <= acc_status_match;
    end
  end

  assign acc_cmd_valid = (state == ISSUE);
  assign acc_cmd_addr  = cur_addr;
  assign acc_cmd_len   = cur_len;

  assign busy = (state != IDLE) || (cmd_count != '0) || (res_count != '0);

`ifdef REGEX_CMDQ_STATS_EN
  logic [31:0] scans_q;
  logic [31:0] matches_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      scans_q   <= '0;
      matches_q <= '0;
    end else if (res_push) begin
      scans_q <= scans_q + 32'd1;
      if (cur_match) matches_q <= matches_q + 32'd1;
    end
  end

  assign stat_scans   = scans_q;
  assign stat_matches = matches_q;
`else
  assign stat_scans   = '0;
  assign stat_matches = '0;
`endif

endmodule
